dht11_onewire_ctrl: RTL

- Protocol engine that drives the DHT11 single-wire bus and produces the humidity/temperature words consumed by the AXI4-Lite register slave of the DHT11 IP.
- The register slave issues a one-cycle start pulse. This block performs the 18 ms host start, sensor response handshake, 40-bit capture and checksum check. It then presents registered results plus status.
- Sits between the bidirectional pad (open-drain emulation) and the AXI register file.

---
 rtl/dht11_pkg.sv | 18 +
 rtl/dht11_us_tick.sv | 17 +
 rtl/dht11_onewire_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared states, frame layout and checksum helper for the DHT11 controller
package dht11_pkg;
  typedef enum logic [2:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_e;
  localparam int NUM_BITS  = 40;
  localparam int B_HUM_INT = 4;
  localparam int B_HUM_DEC = 3;
  localparam int B_TMP_INT = 2;
  localparam int B_TMP_DEC = 1;
  localparam int B_SUM     = 0;
  // The first received byte lands in the top of the frame because bits arrive MSB-first.
  function automatic logic dht_sum_ok(input logic [NUM_BITS-1:0] f);
    logic [7:0] s;
    s = f[8*B_HUM_INT +: 8] + f[8*B_HUM_DEC +: 8] + f[8*B_TMP_INT +: 8] + f[8*B_TMP_DEC +: 8];
    return s == f[8*B_SUM +: 8];
  endfunction
endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: free-running prescaler emitting a one-cycle strobe every microsecond
module dht11_us_tick #(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic ACLK,
  input  logic ARESETN,
  output logic tick_o
);
  localparam int W = $clog2(CLK_FREQ_MHZ > 1 ? CLK_FREQ_MHZ : 2);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = cnt_q == W'(CLK_FREQ_MHZ - 1);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge ACLK)
    cnt_q <= !ARESETN ? '0 : cnt_d;
endmodule

// File: rtl/dht11_onewire_ctrl.sv
// dht11_onewire_ctrl: DHT11 single-wire protocol engine (start pulse, handshake,
// 40-bit capture, checksum) with registered results and sticky status.
module dht11_onewire_ctrl
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_MHZ  = 100,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 255,
  parameter int BIT_THRESH_US = 40
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        checksum_err,
  output logic        timeout_err
);
  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 prev_q, us_tick, rise, fall, to_hit, wait_st;
  logic [15:0]          us_q, us_d, hum_d, tmp_d;
  logic [5:0]           bit_q, bit_d;
  logic [NUM_BITS-1:0]  sh_q, sh_d;
  logic                 dv_d, cs_d, to_d;

  dht11_us_tick #(.CLK_FREQ_MHZ(CLK_FREQ_MHZ)) u_tick (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .tick_o (us_tick)
  );

  assign rise    = sync_q[1] & ~prev_q;
  assign fall    = ~sync_q[1] & prev_q;
  assign to_hit  = us_q == 16'(TIMEOUT_US);
  assign wait_st = state_q inside {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    hum_d   = humidity;
    tmp_d   = temperature;
    dv_d    = 1'b0;
    cs_d    = checksum_err;
    to_d    = timeout_err;
    case (state_q)
      IDLE:      if (start) begin
                   state_d = START_LOW;
                   cs_d    = 1'b0;
                   to_d    = 1'b0;
                 end
      START_LOW: state_d = us_q == 16'(START_LOW_US) ? WAIT_RESP : START_LOW;
      WAIT_RESP: state_d = fall ? RESP_LOW : WAIT_RESP;
      RESP_LOW:  state_d = rise ? RESP_HIGH : RESP_LOW;
      RESP_HIGH: if (fall) begin
                   state_d = BIT_LOW;
                   bit_d   = '0;
                 end
      BIT_LOW:   state_d = rise ? BIT_HIGH : BIT_LOW;
      BIT_HIGH:  if (fall) begin
                   sh_d    = {sh_q[NUM_BITS-2:0], us_q > 16'(BIT_THRESH_US)};
                   bit_d   = bit_q + 1'b1;
                   state_d = bit_q == 6'(NUM_BITS - 1) ? CHECK : BIT_LOW;
                 end
      default:   begin
                   state_d = IDLE;
                   if (dht_sum_ok(sh_q)) begin
                     hum_d = sh_q[8*B_HUM_DEC +: 16];
                     tmp_d = sh_q[8*B_TMP_DEC +: 16];
                     dv_d  = 1'b1;
                   end else cs_d = 1'b1;
                 end
    endcase
    // An edge seen in the same cycle as the timeout has already moved the state on.
    if (wait_st && state_d == state_q && to_hit) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end
    us_d = state_d != state_q ? '0 : (us_tick && us_q != 16'hFFFF) ? us_q + 1'b1 : us_q;
  end

  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      us_q         <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      humidity     <= '0;
      temperature  <= '0;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
      dht_oe       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], dht_in};
      prev_q       <= sync_q[1];
      us_q         <= us_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      humidity     <= hum_d;
      temperature  <= tmp_d;
      data_valid   <= dv_d;
      checksum_err <= cs_d;
      timeout_err  <= to_d;
      busy         <= state_d != IDLE;
      dht_oe       <= state_d == START_LOW;
    end
endmodule
